// File: rtl/soc_mailbox_pkg.sv
// Shared types, register offsets and byte-merge helper for the SoC result mailbox.
// Optional macro SOC_MAILBOX_ERR_LOG_EN adds the ERRCNT offset to the decode.
package soc_mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } mbox_state_e;

  localparam logic [4:0] OFF_FLAG   = 5'h00;
  localparam logic [4:0] OFF_RESULT = 5'h04;
  localparam logic [4:0] OFF_CYCLES = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_ERRCNT = 5'h10;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/soc_mailbox_watchdog.sv
// Run-state FSM, saturating RUN cycle counter and watchdog expiry compare.
// Terminal states (DONE/TIMEOUT) hold until reset; done/timeout decode from state.
module soc_mailbox_watchdog
  import soc_mailbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1500,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_enable_i,
  input  logic             flag_done_i,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  mbox_state_e      r_state;
  mbox_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (fetch_enable_i) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (fetch_enable_i && (r_cnt != {CNT_W{1'b1}})) w_cnt_nxt = r_cnt + 1'b1;
        // A completing FLAG write on the expiry edge takes priority over timeout.
        if (flag_done_i)                               w_state_nxt = DONE;
        else if (fetch_enable_i && (r_cnt == LIMIT))   w_state_nxt = TIMEOUT;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign state_o       = r_state;
  assign done_o        = (r_state == DONE);
  assign timeout_o     = (r_state == TIMEOUT);
  assign cycle_count_o = r_cnt;

endmodule

// File: rtl/soc_result_mailbox.sv
// Memory-mapped result mailbox: bus decode, FLAG/RESULT registers, response pipeline.
// Define SOC_MAILBOX_ERR_LOG_EN to add error_i and the ERRCNT register at 0x10.
module soc_result_mailbox
  import soc_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 1500,
  parameter int          CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_enable_i,
`ifdef SOC_MAILBOX_ERR_LOG_EN
  input  logic             error_i,
`endif
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic [31:0]      mem_flag_o,
  output logic [31:0]      mem_result_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  logic             w_hit;
  logic [4:0]       w_off;
  logic             w_wr;
  logic             w_flag_wr;
  logic             w_flag_done;
  logic [31:0]      w_flag_new;
  logic [31:0]      w_rd;
  logic [1:0]       w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;
  logic             w_timeout;
  logic [31:0]      r_flag;
  logic [31:0]      r_result;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

`ifdef SOC_MAILBOX_ERR_LOG_EN
  logic             r_err_d;
  logic [15:0]      r_errcnt;
  assign w_hit = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign w_off = data_addr_i[4:0];
`else
  assign w_hit = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off = {1'b0, data_addr_i[3:0]};
`endif

  assign w_wr        = w_hit && data_we_i;
  assign w_flag_wr   = w_wr && (w_off == OFF_FLAG);
  assign w_flag_new  = be_merge(r_flag, data_wdata_i, data_be_i);
  assign w_flag_done = w_flag_wr && (w_flag_new != 32'd0);

  soc_mailbox_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_enable_i (fetch_enable_i),
    .flag_done_i    (w_flag_done),
    .state_o        (w_state),
    .done_o         (w_done),
    .timeout_o      (w_timeout),
    .cycle_count_o  (w_cnt)
  );

  always_comb begin
    w_rd = 32'd0;
    case (w_off)
      OFF_FLAG:   w_rd = r_flag;
      OFF_RESULT: w_rd = r_result;
      OFF_CYCLES: w_rd = 32'(w_cnt);
      OFF_STATUS: w_rd = {28'd0, w_state, w_timeout, w_done};
`ifdef SOC_MAILBOX_ERR_LOG_EN
      OFF_ERRCNT: w_rd = {16'd0, r_errcnt};
`endif
      default:    w_rd = 32'd0;
    endcase
  end

  // Grant edge: register writes and capture of the one-cycle response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flag   <= '0;
      r_result <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_flag_wr)                            r_flag   <= w_flag_new;
      if (w_wr && (w_off == OFF_RESULT))        r_result <= be_merge(r_result, data_wdata_i, data_be_i);
      r_rvalid <= w_hit;
      r_rdata  <= (w_hit && !data_we_i) ? w_rd : 32'd0;
    end
  end

`ifdef SOC_MAILBOX_ERR_LOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_d  <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_err_d <= error_i;
      if (error_i && !r_err_d && (w_state == RUN) && (r_errcnt != 16'hFFFF))
        r_errcnt <= r_errcnt + 16'd1;
    end
  end
`endif

  assign data_gnt_o    = w_hit;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign mem_flag_o    = r_flag;
  assign mem_result_o  = r_result;
  assign done_o        = w_done;
  assign timeout_o     = w_timeout;
  assign cycle_count_o = w_cnt;

endmodule

// File: doc/soc_result_mailbox.md
Name: soc_result_mailbox

Overview:
- Memory-mapped result mailbox on the SoC data bus, downstream of the fault-tolerant core's data port.
- Captures the program's flag and result writes and drives them to top-level pins, where the bench consumes them.
- Adds a run-cycle counter, a sticky watchdog timeout and a run-state FSM, so end of program and hangs are visible in hardware.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of the mailbox window (16-byte aligned).
- TIMEOUT_CYCLES, 1500, running cycles before timeout; legal range 1 to 2^CNT_W-1.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- fetch_enable_i  in  1  core run enable; starts the run
- data_req_i  in  1  bus request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  grant (combinational)
- data_rvalid_o  out  1  response valid, one cycle after grant
- data_rdata_o  out  32  read data
- mem_flag_o  out  32  FLAG register
- mem_result_o  out  32  RESULT register
- done_o  out  1  program has signalled completion
- timeout_o  out  1  watchdog expired (sticky)
- cycle_count_o  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset: one clk_i edge with rst_i=1 zeroes all registers and sets the FSM to IDLE. Every output reads 0 after reset, including rvalid and rdata. Reset wins over every other event in the same cycle, including mid-run.
- Address decode: hit when req=1 and addr[31:4]==BASE_ADDR[31:4]. Offsets:
  - 0x0 FLAG, RW
  - 0x4 RESULT, RW
  - 0x8 CYCLES, RO
  - 0xC STATUS, RO: bit0 done, bit1 timeout, bits[3:2] FSM state
- Handshake:
  - gnt_o = hit, same cycle; no wait states.
  - rvalid_o asserts exactly one cycle after every granted access, reads and writes alike.
  - rdata_o is valid while rvalid_o=1 and is 0 otherwise; writes return 0.
  - Back-to-back accesses are accepted every cycle.
- Writes:
  - Applied at the grant edge, byte-masked by be_i.
  - Writes to RO offsets are ignored but still granted.
  - Read-after-write to the same register in the next access returns the new value.
- FSM states: IDLE (0), RUN (1), DONE (2), TIMEOUT (3).
  - IDLE -> RUN when fetch_enable_i=1. The CYCLES counter clears on entry.
  - RUN: CYCLES increments each cycle and saturates at all-ones.
  - RUN -> DONE on the edge where a granted write leaves FLAG != 0. done_o is set that same edge, so mem_flag_o and done_o rise together.
  - RUN -> TIMEOUT when CYCLES == TIMEOUT_CYCLES-1 and no completing FLAG write occurs that edge. A FLAG write in the same cycle wins, giving DONE.
  - fetch_enable_i=0 in RUN pauses counting; the state is held.
  - DONE and TIMEOUT are terminal until reset. Counting stops. FLAG and RESULT remain writable. timeout_o stays 1.
- Writing FLAG=0 in RUN does not complete the run.

Optional Feature:
- Macro SOC_MAILBOX_ERR_LOG_EN.
- When defined:
  - Adds input error_i (1 bit), the fault-injection pulse.
  - Adds RO register ERRCNT at offset 0x10; the decode window becomes 32 bytes.
  - ERRCNT counts rising edges of error_i, and only in RUN.
  - 16 bits wide, saturating, zero-extended on read.
- When undefined:
  - No error_i port, no ERRCNT.
  - Offset 0x10 is outside the window: no grant.

Decomposition:
- Package soc_mailbox_pkg holds:
  - enum mbox_state_e {IDLE, RUN, DONE, TIMEOUT}
  - offset localparams OFF_FLAG, OFF_RESULT, OFF_CYCLES, OFF_STATUS, OFF_ERRCNT
  - helper function be_merge(old, wdata, be)
- One sub-module, soc_mailbox_watchdog, holds the FSM, the cycle counter and the timeout compare. The top module keeps decode, registers and the response pipeline.

Test Plan:
- Reset then read STATUS -> rvalid one cycle after gnt; rdata=0; all outputs 0.
- fetch_enable=1; write RESULT=55 (be=4'hF); write FLAG=1 -> mem_result_o=55, mem_flag_o=1 and done_o=1 on the same edge; STATUS bit0=1 and state=2; CYCLES frozen.
- Write RESULT=32'hFFFF_FFFF, then write 32'h0000_0012 with be=4'b0001 -> read RESULT = 32'hFFFF_FF12.
- TIMEOUT_CYCLES=20, no FLAG write -> timeout_o=1 after 20 RUN cycles and stays 1; a later FLAG write updates mem_flag_o but done_o stays 0.
- FLAG write on the exact expiry cycle -> state DONE, timeout_o=0. Assert rst_i mid-run -> all outputs 0 next edge, FSM IDLE.
- With SOC_MAILBOX_ERR_LOG_EN: three error_i pulses of 2 cycles each in RUN, plus one in IDLE -> ERRCNT=3. Without the macro: access to 0x10 -> gnt_o=0.
